// File: rtl/pi1_arbiter.sv
// Round-robin arbiter sharing one pi1 slave port among MASTERCOUNT pi1 masters.
// Grant is combinational; ownership is held while an accepted read waits for its data.
module pi1_arbiter #(
    parameter int unsigned MASTERCOUNT = 2,
    parameter int unsigned ARCHBITSZ   = 32,
    parameter int unsigned ADDRBITSZ   = ARCHBITSZ - $clog2(ARCHBITSZ / 8)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [2*MASTERCOUNT-1:0]             m_pi1_op_i,
    input  logic [ADDRBITSZ*MASTERCOUNT-1:0]     m_pi1_addr_i,
    input  logic [ARCHBITSZ*MASTERCOUNT-1:0]     m_pi1_data_i,
    input  logic [(ARCHBITSZ/8)*MASTERCOUNT-1:0] m_pi1_sel_i,
    output logic [ARCHBITSZ-1:0]                 m_pi1_data_o,
    output logic [MASTERCOUNT-1:0]               m_pi1_rdy_o,
    output logic [1:0]                           s_pi1_op_o,
    output logic [ADDRBITSZ-1:0]                 s_pi1_addr_o,
    output logic [ARCHBITSZ-1:0]                 s_pi1_data_o,
    output logic [ARCHBITSZ/8-1:0]               s_pi1_sel_o,
    input  logic [ARCHBITSZ-1:0]                 s_pi1_data_i,
    input  logic                                 s_pi1_rdy_i
);

    localparam int unsigned IDXW = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1;
    localparam int unsigned SELW = ARCHBITSZ / 8;
    localparam logic [1:0]  OP_NOOP = 2'b00;

    logic [1:0]           op_a   [MASTERCOUNT];
    logic [ADDRBITSZ-1:0] addr_a [MASTERCOUNT];
    logic [ARCHBITSZ-1:0] data_a [MASTERCOUNT];
    logic [SELW-1:0]      sel_a  [MASTERCOUNT];

    logic [IDXW-1:0] lastidx;
    logic            pending;
    logic [IDXW-1:0] cur;
    logic [IDXW-1:0] scan;
    logic            found;
    logic            accept;

    // Unpack the per-master buses into arrays indexed by master number.
    for (genvar k = 0; k < MASTERCOUNT; k++) begin : g_unpack
        assign op_a[k]   = m_pi1_op_i[2*k +: 2];
        assign addr_a[k] = m_pi1_addr_i[ADDRBITSZ*k +: ADDRBITSZ];
        assign data_a[k] = m_pi1_data_i[ARCHBITSZ*k +: ARCHBITSZ];
        assign sel_a[k]  = m_pi1_sel_i[SELW*k +: SELW];
    end

    // Current master: owner while a read is pending, else first requester after lastidx.
    always_comb begin
        cur   = lastidx;
        scan  = lastidx;
        found = 1'b0;
        for (int i = 0; i < MASTERCOUNT; i++) begin
            if (scan == IDXW'(MASTERCOUNT - 1)) begin
                scan = '0;
            end else begin
                scan = scan + IDXW'(1);
            end
            if (!found && op_a[scan] != OP_NOOP) begin
                cur   = scan;
                found = 1'b1;
            end
        end
        if (pending) begin
            cur = lastidx;
        end
        if (rst_i) begin
            cur = '0;
        end
    end

    always_comb begin
        s_pi1_op_o   = rst_i ? OP_NOOP : op_a[cur];
        s_pi1_addr_o = addr_a[cur];
        s_pi1_data_o = data_a[cur];
        s_pi1_sel_o  = sel_a[cur];
        m_pi1_data_o = s_pi1_data_i;
        m_pi1_rdy_o  = '0;
        for (int k = 0; k < MASTERCOUNT; k++) begin
            if (cur == IDXW'(k)) begin
                m_pi1_rdy_o[k] = s_pi1_rdy_i && !rst_i;
            end
        end
    end

    assign accept = s_pi1_rdy_i && !rst_i && (s_pi1_op_o != OP_NOOP);

    // A completion with a fresh op from the owner chains; otherwise a ready clears the lock.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lastidx <= IDXW'(MASTERCOUNT - 1);
            pending <= 1'b0;
        end else if (accept) begin
            lastidx <= cur;
            pending <= s_pi1_op_o[1];
        end else if (pending && s_pi1_rdy_i && op_a[cur] == OP_NOOP) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pi1_arbiter.sv
// Directed bench for pi1_arbiter with three masters: reset, rotation, read lock,
// chained reads, reset during a read and the non-power-of-2 wrap.
module tb_pi1_arbiter;

    localparam int unsigned MC    = 3;
    localparam int unsigned AW    = 32;
    localparam int unsigned ADW   = 30;
    localparam int unsigned SW    = 4;

    logic            clk;
    logic            rst;
    logic [1:0]      op_a   [MC];
    logic [ADW-1:0]  addr_a [MC];
    logic [AW-1:0]   wdat_a [MC];
    logic [SW-1:0]   sel_a  [MC];
    logic [2*MC-1:0]   m_op;
    logic [ADW*MC-1:0] m_addr;
    logic [AW*MC-1:0]  m_wdata;
    logic [SW*MC-1:0]  m_sel;
    logic [AW-1:0]   m_rdata;
    logic [MC-1:0]   m_rdy;
    logic [1:0]      s_op;
    logic [ADW-1:0]  s_addr;
    logic [AW-1:0]   s_wdata;
    logic [SW-1:0]   s_sel;
    logic [AW-1:0]   s_rdata;
    logic            s_rdy;

    int errors = 0;
    int checks = 0;

    always_comb begin
        for (int k = 0; k < MC; k++) begin
            m_op[2*k +: 2]      = op_a[k];
            m_addr[ADW*k +: ADW] = addr_a[k];
            m_wdata[AW*k +: AW]  = wdat_a[k];
            m_sel[SW*k +: SW]    = sel_a[k];
        end
    end

    pi1_arbiter #(.MASTERCOUNT(MC), .ARCHBITSZ(AW), .ADDRBITSZ(ADW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .m_pi1_op_i   (m_op),
        .m_pi1_addr_i (m_addr),
        .m_pi1_data_i (m_wdata),
        .m_pi1_sel_i  (m_sel),
        .m_pi1_data_o (m_rdata),
        .m_pi1_rdy_o  (m_rdy),
        .s_pi1_op_o   (s_op),
        .s_pi1_addr_o (s_addr),
        .s_pi1_data_o (s_wdata),
        .s_pi1_sel_o  (s_sel),
        .s_pi1_data_i (s_rdata),
        .s_pi1_rdy_i  (s_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ops(input logic [1:0] o0, input logic [1:0] o1, input logic [1:0] o2);
        op_a[0] = o0;
        op_a[1] = o1;
        op_a[2] = o2;
    endtask

    // One reset edge with all masters idle; leaves lastidx=2, pending=0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_ops(2'b00, 2'b00, 2'b00);
        s_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        set_ops(2'b10, 2'b10, 2'b10);
        s_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checks++;
            if (m_rdy !== 3'b000) begin
                errors++;
                $display("FAIL reset_rdy cyc=%0d got=%b exp=000", i, m_rdy);
            end
            checks++;
            if (s_op !== 2'b00) begin
                errors++;
                $display("FAIL reset_op cyc=%0d got=%b exp=00", i, s_op);
            end
            checks++;
            if (s_addr !== addr_a[0]) begin
                errors++;
                $display("FAIL reset_addr cyc=%0d got=%h exp=%h", i, s_addr, addr_a[0]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (m_rdy !== 3'b001) begin
            errors++;
            $display("FAIL post_reset_grant got=%b exp=001", m_rdy);
        end
        checks++;
        if (s_addr !== addr_a[0]) begin
            errors++;
            $display("FAIL post_reset_addr got=%h exp=%h", s_addr, addr_a[0]);
        end
    endtask

    task automatic test_rr_writes();
        int exp_g;
        do_reset();
        @(negedge clk);
        set_ops(2'b01, 2'b01, 2'b01);
        s_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_g = i % 3;
            checks++;
            if (m_rdy !== 3'(1 << exp_g)) begin
                errors++;
                $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, m_rdy, 3'(1 << exp_g));
            end
            checks++;
            if (s_op !== 2'b01 || s_addr !== addr_a[exp_g] || s_wdata !== wdat_a[exp_g]
                || s_sel !== sel_a[exp_g]) begin
                errors++;
                $display("FAIL rr_mux cyc=%0d got op=%b addr=%h data=%h sel=%h exp master %0d",
                         i, s_op, s_addr, s_wdata, s_sel, exp_g);
            end
        end
    endtask

    task automatic test_read_lock();
        do_reset();
        @(negedge clk);
        addr_a[0] = 30'h40;
        set_ops(2'b10, 2'b01, 2'b00);
        s_rdy = 1'b1;
        #1;
        checks++;
        if (m_rdy !== 3'b001 || s_op !== 2'b10 || s_addr !== 30'h40) begin
            errors++;
            $display("FAIL lock_issue got rdy=%b op=%b addr=%h exp rdy=001 op=10 addr=40",
                     m_rdy, s_op, s_addr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_ops(2'b00, 2'b01, 2'b00);
            s_rdy = 1'b0;
            #1;
            checks++;
            if (m_rdy !== 3'b000) begin
                errors++;
                $display("FAIL lock_wait cyc=%0d got=%b exp=000", i, m_rdy);
            end
        end
        @(negedge clk);
        s_rdy   = 1'b1;
        s_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (m_rdy !== 3'b001 || m_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lock_data got rdy=%b data=%h exp rdy=001 data=deadbeef", m_rdy, m_rdata);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_rdy !== 3'b010 || s_op !== 2'b01 || s_addr !== addr_a[1]) begin
            errors++;
            $display("FAIL lock_release got rdy=%b op=%b addr=%h exp rdy=010 op=01 addr=%h",
                     m_rdy, s_op, s_addr, addr_a[1]);
        end
    endtask

    task automatic test_chained_read();
        do_reset();
        @(negedge clk);
        set_ops(2'b10, 2'b01, 2'b00);
        s_rdy = 1'b1;
        #1;
        checks++;
        if (m_rdy !== 3'b001) begin
            errors++;
            $display("FAIL chain_first got=%b exp=001", m_rdy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_rdy !== 3'b001 || s_op !== 2'b10) begin
            errors++;
            $display("FAIL chain_second got rdy=%b op=%b exp rdy=001 op=10", m_rdy, s_op);
        end
        @(negedge clk);
        set_ops(2'b00, 2'b01, 2'b00);
        s_rdy = 1'b0;
        #1;
        checks++;
        if (m_rdy !== 3'b000) begin
            errors++;
            $display("FAIL chain_pending got=%b exp=000", m_rdy);
        end
        @(negedge clk);
        s_rdy = 1'b1;
        #1;
        checks++;
        if (m_rdy !== 3'b001 || s_op !== 2'b00) begin
            errors++;
            $display("FAIL chain_complete got rdy=%b op=%b exp rdy=001 op=00", m_rdy, s_op);
        end
        @(negedge clk);
        #1;
        checks++;
        if (m_rdy !== 3'b010 || s_op !== 2'b01) begin
            errors++;
            $display("FAIL chain_release got rdy=%b op=%b exp rdy=010 op=01", m_rdy, s_op);
        end
    endtask

    task automatic test_reset_during_read();
        do_reset();
        @(negedge clk);
        set_ops(2'b10, 2'b01, 2'b00);
        s_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_ops(2'b00, 2'b01, 2'b00);
            s_rdy = 1'b0;
        end
        @(negedge clk);
        rst   = 1'b1;
        s_rdy = 1'b1;
        #1;
        checks++;
        if (m_rdy !== 3'b000 || s_op !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid got rdy=%b op=%b exp rdy=000 op=00", m_rdy, s_op);
        end
        @(negedge clk);
        rst = 1'b0;
        set_ops(2'b00, 2'b00, 2'b00);
        #1;
        checks++;
        if (m_rdy !== 3'b100 || s_op !== 2'b00) begin
            errors++;
            $display("FAIL rst_stray got rdy=%b op=%b exp rdy=100 op=00", m_rdy, s_op);
        end
        @(negedge clk);
        set_ops(2'b00, 2'b01, 2'b00);
        #1;
        checks++;
        if (m_rdy !== 3'b010 || s_op !== 2'b01) begin
            errors++;
            $display("FAIL rst_cleared got rdy=%b op=%b exp rdy=010 op=01", m_rdy, s_op);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        set_ops(2'b00, 2'b01, 2'b00);
        s_rdy = 1'b1;
        #1;
        checks++;
        if (m_rdy !== 3'b010) begin
            errors++;
            $display("FAIL wrap_m1 got=%b exp=010", m_rdy);
        end
        @(negedge clk);
        set_ops(2'b00, 2'b00, 2'b01);
        #1;
        checks++;
        if (m_rdy !== 3'b100 || s_addr !== addr_a[2]) begin
            errors++;
            $display("FAIL wrap_m2 got rdy=%b addr=%h exp rdy=100 addr=%h", m_rdy, s_addr, addr_a[2]);
        end
        @(negedge clk);
        set_ops(2'b01, 2'b00, 2'b00);
        #1;
        checks++;
        if (m_rdy !== 3'b001 || s_op !== 2'b01 || s_addr !== addr_a[0]) begin
            errors++;
            $display("FAIL wrap_m0 got rdy=%b op=%b addr=%h exp rdy=001 op=01 addr=%h",
                     m_rdy, s_op, s_addr, addr_a[0]);
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_rdy   = 1'b0;
        s_rdata = '0;
        for (int k = 0; k < MC; k++) begin
            op_a[k]   = 2'b00;
            addr_a[k] = 30'(32'h100 * (k + 1));
            wdat_a[k] = 32'hA000_0000 + 32'(k);
            sel_a[k]  = 4'(k + 5);
        end
        test_reset();
        test_rr_writes();
        test_read_lock();
        test_chained_read();
        test_reset_during_read();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
